// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register file, decode and writeback.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_clear_seq.sv
// CLEAR/RUN sequencer: walks clr_ptr over every entry after reset or a clr request,
// then enters RUN and raises ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              clr,
    output rf_state_e         state,
    output logic [ADDR_W-1:0] clr_ptr,
    output logic              ready
);

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    // Last entry cleared on this edge; the pointer wrap is never used.
                    if (clr_ptr == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised register file: N_RD read ports, two write ports (B wins), clear-after-reset,
// registered collision flag. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned N_RD     = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rstd,
    input  logic                   clr,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    input  logic                   wa_en,
    input  logic [ADDR_W-1:0]      wa_addr,
    input  logic [DATA_W-1:0]      wa_data,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   ready,
    output logic                   wr_collide
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    rf_state_e         state;
    logic [ADDR_W-1:0] clr_ptr;
    logic              run;
    logic              wa_ok;
    logic              wb_ok;
    logic              same_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .rstd    (rstd),
        .clr     (clr),
        .state   (state),
        .clr_ptr (clr_ptr),
        .ready   (ready)
    );

    assign run = (state == RUN);

    // A write is effective only in RUN, not on a clr edge, and never to a hardwired zero entry.
    assign wa_ok = run && !clr && wa_en && !(ZERO_REG != 0 && wa_addr == '0);
    assign wb_ok = run && !clr && wb_en && !(ZERO_REG != 0 && wb_addr == '0);

    assign same_addr = wa_en && wb_en && (wa_addr == wb_addr)
                       && !(ZERO_REG != 0 && wa_addr == '0);

    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_ptr] <= '0;
        end else begin
            if (wa_ok) mem[wa_addr] <= wa_data;
            if (wb_ok) mem[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            wr_collide <= 1'b0;
        end else begin
            wr_collide <= run && same_addr;
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] lane_addr;
        logic [DATA_W-1:0] lane_data;

        assign lane_addr = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            lane_data = mem[lane_addr];
`ifdef REGFILE_BYPASS_EN
            if (wa_ok && wa_addr == lane_addr) lane_data = wa_data;
            if (wb_ok && wb_addr == lane_addr) lane_data = wb_data;
`endif
            // Partially cleared contents must never leak out.
            if (!run || (ZERO_REG != 0 && lane_addr == '0)) lane_data = '0;
        end

        assign rd_data[i*DATA_W +: DATA_W] = lane_data;
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench for multiport_regfile (default parameters) against an abstract model.
module tb_multiport_regfile;

    logic        clk = 1'b0;
    logic        rstd = 1'b0;
    logic        clr = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        wa_en = 1'b0;
    logic [4:0]  wa_addr = '0;
    logic [31:0] wa_data = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ready;
    logic        wr_collide;

    int total = 0;
    int bad = 0;

    // Model: contents become all-zero the moment a clear starts (they are invisible until it
    // ends), and m_left counts the clear edges still to go.
    logic [31:0] m_mem [32];
    bit          m_run;
    int          m_left;
    logic        m_col;

    multiport_regfile dut (
        .clk        (clk),
        .rstd       (rstd),
        .clr        (clr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wa_en      (wa_en),
        .wa_addr    (wa_addr),
        .wa_data    (wa_data),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ready      (ready),
        .wr_collide (wr_collide)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_restart();
        for (int k = 0; k < 32; k++) m_mem[k] = '0;
        m_run  = 1'b0;
        m_left = 32;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        if (!m_run || a == 5'd0) return 32'h0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (!clr && wa_en && wa_addr == a) v = wa_data;
        if (!clr && wb_en && wb_addr == a) v = wb_data;
`endif
        return v;
    endfunction

    task automatic check_all(input string tag);
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("%s.rd%0d@%0d", tag, i, rd_addr[i*5 +: 5]),
                  rd_data[i*32 +: 32], exp_rd(rd_addr[i*5 +: 5]));
        check({tag, ".ready"}, {31'b0, ready}, {31'b0, m_run});
        check({tag, ".collide"}, {31'b0, wr_collide}, {31'b0, m_col});
    endtask

    // One rising edge; inputs are sampled before it and the model updated after it.
    task automatic tick();
        bit          s_clr = clr;
        bit          s_wa = wa_en;
        bit          s_wb = wb_en;
        logic [4:0]  s_aa = wa_addr;
        logic [4:0]  s_ba = wb_addr;
        logic [31:0] s_ad = wa_data;
        logic [31:0] s_bd = wb_data;
        @(posedge clk);
        #1;
        m_col = m_run && s_wa && s_wb && s_aa == s_ba && s_aa != 5'd0;
        if (!m_run) begin
            m_left--;
            if (m_left == 0) m_run = 1'b1;
        end else if (s_clr) begin
            model_restart();
        end else begin
            if (s_wa && s_aa != 5'd0) m_mem[s_aa] = s_ad;
            if (s_wb && s_ba != 5'd0) m_mem[s_ba] = s_bd;
        end
    endtask

    task automatic idle();
        clr = 1'b0;
        wa_en = 1'b0;
        wb_en = 1'b0;
    endtask

    task automatic rand_writes();
        wa_en   = 1'($urandom_range(0, 1));
        wb_en   = 1'($urandom_range(0, 1));
        wa_addr = 5'($urandom_range(0, 7));
        wb_addr = 5'($urandom_range(0, 7));
        wa_data = $urandom;
        wb_data = $urandom;
        rd_addr = 10'($urandom);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            check_all(tag);
        end
    endtask

    initial begin
        // Reset state, then the clear sequence.
        model_restart();
        m_col = 1'b0;
        rstd = 1'b0;
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rstd = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            tick();
            rd_addr = 10'($urandom);
            check_all($sformatf("clear%0d", n));
        end
        read_all("after_clear");

        // Single write on port A.
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        rd_addr = {5'd9, 5'd5};
        check_all("wa5_same");
        tick();
        idle();
        check_all("wa5_next");

        // A and B collide on address 9; B wins, flag pulses one cycle.
        wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h11111111;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h22222222;
        tick();
        idle();
        check_all("col9");
        check("col9.data", rd_data[63:32], 32'h22222222);
        check("col9.flag", {31'b0, wr_collide}, 32'h1);
        tick();
        check_all("col9_after");

        // Address 0 is hardwired zero and excluded from collision.
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h0BADF00D;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        rd_addr = {5'd9, 5'd0};
        check_all("zero_same");
        tick();
        idle();
        check_all("zero_next");

        // clr request: writes during the clear are ignored, entry 31 ends up zero.
        wa_en = 1'b1; wa_addr = 5'd31; wa_data = 32'h12345678;
        tick();
        idle();
        rd_addr = {5'd5, 5'd31};
        check_all("w31");
        clr = 1'b1;
        tick();
        for (int n = 1; n <= 32; n++) begin
            rand_writes();
            clr = 1'($urandom_range(0, 1));
            check_all($sformatf("reclear%0d", n));
            tick();
        end
        idle();
        rd_addr = {5'd5, 5'd31};
        check_all("reclear_done");
        read_all("reclear_read");

        // Randomised traffic with occasional clr.
        for (int n = 0; n < 400; n++) begin
            rand_writes();
            clr = ($urandom_range(0, 99) == 0);
            check_all("rand_pre");
            tick();
        end
        idle();
        for (int n = 0; n < 40; n++) tick();
        read_all("rand_read");

        // Reset asserted at the 10th clear edge restarts from entry 0.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int n = 0; n < 9; n++) tick();
        @(negedge clk);
        rstd = 1'b0;
        model_restart();
        m_col = 1'b0;
        check_all("midclear_rst");
        repeat (3) @(posedge clk);
        #1;
        rstd = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            tick();
            check_all($sformatf("rst_clear%0d", n));
        end
        read_all("rst_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised general-purpose register file for the MIPS-style core. It replaces the fixed 32×32, 2-read/1-write file with one that is configurable in width, depth and read-port count. It adds a second write port, hardware clear-after-reset, a registered write-collision flag, and optional same-cycle write-to-read bypass. It sits between decode (read addresses) and writeback (ALU and load results).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (derived, not overridable)
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, entry 0 hardwired to zero when 1; ordinary register when 0

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstd  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous request to re-run the clear sequence
- rd_addr  in  N_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  packed read data, combinational from rd_addr
- wa_en / wa_addr / wa_data  in  1 / ADDR_W / DATA_W  write port A (ALU result)
- wb_en / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  write port B (load result)
- ready  out  1  high when the file is in RUN and accepts writes
- wr_collide  out  1  registered one-cycle pulse when A and B write the same address

## Operation
- The state machine has two states, CLEAR and RUN. A pointer clr_ptr[ADDR_W-1:0] is used in CLEAR.
- rstd low, asynchronously: the state goes to CLEAR, clr_ptr to 0, ready to 0 and wr_collide to 0. Array contents are not reset directly.
- In CLEAR, each rising edge writes 0 to entry clr_ptr and increments clr_ptr. On the edge that clears entry DEPTH-1, the state goes to RUN.
- In CLEAR, wa_en and wb_en are ignored, clr is ignored, and every rd_data lane reads 0.
- In RUN, a rising edge with clr=1 returns the state to CLEAR with clr_ptr=0. Writes presented on that same edge are discarded.
- A write in RUN stores wX_data at wX_addr on the rising edge when wX_en=1.
- If A and B target the same address on the same edge, B wins.
- With ZERO_REG=1, writes to address 0 are dropped and reads of address 0 return 0.
- wr_collide is set on the edge where, in RUN, wa_en and wb_en are both 1 and wa_addr equals wb_addr. Address 0 is excluded when ZERO_REG=1. Otherwise wr_collide is cleared.
- A read in RUN returns the stored entry, subject to bypass (see Configuration).
- Width rules: there is no arithmetic on data. clr_ptr wraps naturally at DEPTH-1, but the transition to RUN happens on that edge, so the wrap is never observed.

## Timing
- Reset values: state CLEAR, ready=0, wr_collide=0, all rd_data lanes 0.
- ready rises after exactly DEPTH rising edges following rstd deassertion. With the defaults this is 32 edges.
- Write latency is 1 cycle. Without bypass, data is visible on rd_data after the capturing edge.
- Read latency is 0 cycles (combinational).
- wr_collide is valid the cycle after the colliding edge and lasts one cycle per colliding edge.
- Reset mid-CLEAR or mid-RUN restarts the sequence from entry 0 immediately. Partial contents are never visible.
- clr in RUN: ready falls the cycle after the clr edge and rises DEPTH edges later.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, a read lane whose address matches an enabled write on the current cycle returns the write data combinationally. Port B takes priority over A, and address 0 is excluded when ZERO_REG=1.
- REGFILE_BYPASS_EN undefined: reads always return the stored value. Same-cycle write data appears on the next cycle.

## Structure
- Package regfile_pkg holds:
  - the state enum {CLEAR, RUN}
  - default DATA_W and ADDR_W constants shared with decode and writeback
- Sub-module regfile_clear_seq contains the CLEAR/RUN state machine, clr_ptr and ready. The top level holds the array, the write logic, the read mux with bypass, and wr_collide.

## Test plan
- rstd pulse low, then release -> ready=0 for 32 edges and 1 on the 32nd. Reading all 32 addresses returns 0x00000000.
- RUN: write A to addr 5 with 0xDEADBEEF -> rd_addr0=5 returns 0xDEADBEEF the next cycle. It returns the old value on the write cycle without bypass, and 0xDEADBEEF with REGFILE_BYPASS_EN.
- RUN: A writes 0x11111111 and B writes 0x22222222, both to addr 9 -> addr 9 reads 0x22222222 and wr_collide=1 for exactly one cycle.
- ZERO_REG=1: write B to addr 0 with 0xFFFFFFFF -> addr 0 reads 0 and wr_collide stays 0 even when A also targets addr 0.
- Write 0x12345678 to addr 31, then assert clr for 1 cycle -> ready=0 for 32 edges, writes during CLEAR are ignored, and addr 31 reads 0 afterwards.
- Assert rstd low at the 10th clear edge -> ready stays 0 until 32 edges after release, and all entries read 0.
